// File: rtl/run_length_pkg.sv
// Shared types, defaults and the run_len decode for the run-length transmitter.
package run_length_pkg;

    localparam int unsigned FRAME_BITS_DEF = 1024;
    localparam int unsigned MAX_RUN_DEF    = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned RUN_LEN_W      = 4;
    localparam int unsigned RUNS_W         = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A code of zero stands for the longest run, 16 bits.
    function automatic logic [RUN_LEN_W:0] decode_run_len(input logic [RUN_LEN_W-1:0] len);
        decode_run_len = (len == '0) ? 5'd16 : {1'b0, len};
    endfunction

endpackage

// File: rtl/run_len_fifo.sv
// Small synchronous FIFO holding requested run lengths; head is visible before the pop.
module run_len_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/run_length_tx.sv
// Frame-based run-length serialiser: emits alternating-level runs popped from a FIFO.
module run_length_tx
    import run_length_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned MAX_RUN    = MAX_RUN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 run_valid,
    input  logic [RUN_LEN_W-1:0] run_len,
    output logic                 run_ready,
    output logic                 data_valid,
    output logic                 data_out,
    output logic                 frame_done,
    output logic                 underrun,
    output logic [RUNS_W-1:0]    runs_sent
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam int unsigned REM_W = $clog2(MAX_RUN + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [REM_W-1:0]    r_rem;
    logic                r_level;
    logic                r_data_valid;
    logic                r_data_out;
    logic                r_frame_done;
    logic                r_underrun;
    logic [RUNS_W-1:0]   r_runs_sent;

    logic [RUN_LEN_W-1:0] w_head;
    logic [RUN_LEN_W:0]   w_dec;
    logic [REM_W-1:0]     w_head_len;
    logic [REM_W-1:0]     w_next_len;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_last_bit;
    logic                 w_run_end;
    logic                 w_start_acc;
    logic                 w_run_start;
    logic                 w_push;
    logic                 w_pop;

    run_len_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RUN_LEN_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (run_len),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_dec       = decode_run_len(w_head);
    assign w_head_len  = (32'(w_dec) > MAX_RUN) ? REM_W'(MAX_RUN) : REM_W'(w_dec);
    // An empty FIFO at a run boundary yields a single-bit filler run.
    assign w_next_len  = w_empty ? REM_W'(1) : w_head_len;
    assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign w_run_end   = (r_rem == REM_W'(1));
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_run_start = w_start_acc || ((r_state == ST_SEND) && !w_last_bit && w_run_end);
    assign w_pop       = w_run_start && !w_empty;
    assign w_push      = run_valid && !w_full;

    assign run_ready  = !w_full;
    assign data_valid = r_data_valid;
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
    assign runs_sent  = r_runs_sent;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_rem        <= '0;
            r_level      <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_runs_sent  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_SEND;
                        r_bit_cnt    <= '0;
                        r_level      <= 1'b0;
                        r_data_valid <= 1'b1;
                        r_data_out   <= 1'b0;
                        r_rem        <= w_next_len;
                        r_runs_sent  <= RUNS_W'(1);
                        r_underrun   <= w_empty;
                    end
                end
                ST_SEND: begin
                    if (w_last_bit) begin
                        // Any unfinished run is dropped; queued entries stay for the next frame.
                        r_state      <= ST_DONE;
                        r_data_valid <= 1'b0;
                        r_data_out   <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_run_end) begin
                            r_level     <= ~r_level;
                            r_data_out  <= ~r_level;
                            r_rem       <= w_next_len;
                            r_runs_sent <= r_runs_sent + RUNS_W'(1);
                            if (w_empty) begin
                                r_underrun <= 1'b1;
                            end
                        end else begin
                            r_rem <= r_rem - REM_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_length_tx.sv
// Randomised self-checking bench for run_length_tx against a frame-level reference model.
module tb_run_length_tx;

    localparam int FB = 1024;
    localparam int SEQ_N = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       run_valid = 1'b0;
    logic [3:0] run_len = 4'd0;
    logic       run_ready;
    logic       data_valid;
    logic       data_out;
    logic       frame_done;
    logic       underrun;
    logic [10:0] runs_sent;

    run_length_tx #(
        .FRAME_BITS (1024),
        .MAX_RUN    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .run_valid  (run_valid),
        .run_len    (run_len),
        .run_ready  (run_ready),
        .data_valid (data_valid),
        .data_out   (data_out),
        .frame_done (frame_done),
        .underrun   (underrun),
        .runs_sent  (runs_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Everything ever offered to the FIFO, in order; the model consumes from cons_idx.
    logic [3:0] feed_seq [SEQ_N];
    int  fed_idx = 0;
    int  feed_lim = 0;
    int  cons_idx = 0;
    bit  feed_en = 1'b0;

    logic exp_bits [FB];
    int   exp_runs;
    bit   exp_und;
    int   exp_hist [17];

    logic cap_bits [FB];
    int   nvalid, ndone, done_at, gaps, idle_bad;
    int   cap_hist [17];
    int   cap_max_run;

    // Run-length producer: offers feed_seq entries in order whenever enabled.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = run_valid && run_ready && rst_n;
            @(posedge clk);
            if (acc) fed_idx++;
            #1;
            run_valid = feed_en && (fed_idx < feed_lim);
            run_len   = feed_seq[fed_idx % SEQ_N];
        end
    end

    // Expected frame: runs taken in feed order, levels alternate from 0, clipped at FB bits.
    task automatic model_frame(input bit continuous);
        int avail, pos, lvl, len, emit;
        avail = continuous ? (1 << 30) : (fed_idx - cons_idx);
        pos = 0; lvl = 0; exp_runs = 0; exp_und = 1'b0;
        for (int k = 0; k < 17; k++) exp_hist[k] = 0;
        while (pos < FB) begin
            if (avail > 0) begin
                len = (feed_seq[cons_idx] == 4'd0) ? 16 : int'(feed_seq[cons_idx]);
                cons_idx++;
                avail--;
            end else begin
                len = 1;
                exp_und = 1'b1;
            end
            exp_runs++;
            emit = (len < FB - pos) ? len : FB - pos;
            exp_hist[emit]++;
            for (int k = 0; k < emit; k++) exp_bits[pos + k] = 1'(lvl);
            pos += emit;
            lvl ^= 1;
        end
    endtask

    // Pulses start, records one frame window and derives the observed run histogram.
    task automatic capture_frame(input int p1, input int p2);
        int run;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nvalid = 0; ndone = 0; done_at = -1; gaps = 0; idle_bad = 0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            start = (c == p1) || (c == p2);
            if (data_valid === 1'b1) begin
                if (nvalid < FB) cap_bits[nvalid] = data_out;
                if (c != nvalid) gaps++;
                nvalid++;
            end else if (data_out !== 1'b0) begin
                idle_bad++;
            end
            if (frame_done === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 17; k++) cap_hist[k] = 0;
        cap_max_run = 0;
        run = 1;
        for (int i = 1; i <= FB; i++) begin
            if (i == FB || cap_bits[i] !== cap_bits[i-1]) begin
                if (run <= 16) cap_hist[run]++;
                if (run > cap_max_run) cap_max_run = run;
                run = 1;
            end else begin
                run++;
            end
        end
    endtask

    function automatic int count_diffs();
        int d = 0;
        for (int i = 0; i < FB; i++) if (cap_bits[i] !== exp_bits[i]) d++;
        return d;
    endfunction

    // Stops the producer, then rewrites the not-yet-offered part of the sequence.
    task automatic start_feed(input int mode);
        int base;
        feed_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = fed_idx;
        for (int i = base; i < SEQ_N; i++) begin
            case (mode)
                0:       feed_seq[i] = 4'd0;
                1:       feed_seq[i] = (i - base <= 342) ? 4'd3 : 4'd7;
                2:       feed_seq[i] = 4'($urandom_range(0, 15));
                default: feed_seq[i] = 4'((i - base) % 16 + 1);
            endcase
        end
        feed_lim = SEQ_N;
        feed_en = 1'b1;
    endtask

    task automatic wait_full(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (run_ready === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        feed_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cons_idx = fed_idx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        n_checks++; if (data_out !== 1'b0) begin n_errors++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        n_checks++; if (runs_sent !== 11'd0) begin n_errors++; $display("FAIL reset_runs_sent got=%0d exp=0", runs_sent); end
        n_checks++; if (run_ready !== 1'b1) begin n_errors++; $display("FAIL reset_run_ready got=%b exp=1", run_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_preload_underrun();
        logic [24:0] got_pfx;
        logic [24:0] exp_pfx;
        feed_seq[fed_idx] = 4'd5; feed_seq[fed_idx+1] = 4'd3; feed_seq[fed_idx+2] = 4'd0;
        feed_lim = fed_idx + 3;
        feed_en = 1'b1;
        for (int k = 0; k < 40 && fed_idx < feed_lim; k++) @(negedge clk);
        feed_en = 1'b0;
        n_checks++; if (fed_idx != feed_lim) begin n_errors++; $display("FAIL preload_accept got=%0d exp=%0d", fed_idx, feed_lim); end
        model_frame(1'b0);
        capture_frame(-1, -1);
        exp_pfx = 25'b00000_111_0000000000000000_1;
        for (int i = 0; i < 25; i++) got_pfx[24-i] = cap_bits[i];
        n_checks++; if (got_pfx !== exp_pfx) begin n_errors++; $display("FAIL underrun_prefix got=%b exp=%b", got_pfx, exp_pfx); end
        n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL underrun_bits diffs=%0d exp=0", count_diffs()); end
        n_checks++; if (nvalid != FB || gaps != 0) begin n_errors++; $display("FAIL underrun_valid_len got=%0d gaps=%0d exp=%0d", nvalid, gaps, FB); end
        n_checks++; if (ndone != 1 || done_at != FB) begin n_errors++; $display("FAIL underrun_frame_done count=%0d at=%0d exp=1 at %0d", ndone, done_at, FB); end
        n_checks++; if (underrun !== 1'b1 || exp_und != 1'b1) begin n_errors++; $display("FAIL underrun_flag got=%b exp=1", underrun); end
        n_checks++; if (runs_sent !== 11'(exp_runs)) begin n_errors++; $display("FAIL underrun_runs_sent got=%0d exp=%0d", runs_sent, exp_runs); end
        n_checks++; if (idle_bad != 0) begin n_errors++; $display("FAIL underrun_idle_data got=%0d exp=0", idle_bad); end
    endtask

    task automatic test_all16();
        bit ok;
        start_feed(0);
        wait_full(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL all16_preload got=not_full exp=full"); end
        model_frame(1'b1);
        capture_frame(-1, -1);
        n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL all16_bits diffs=%0d exp=0", count_diffs()); end
        n_checks++; if (runs_sent !== 11'd64 || exp_runs != 64) begin n_errors++; $display("FAIL all16_runs_sent got=%0d exp=64", runs_sent); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL all16_underrun got=%b exp=0", underrun); end
        n_checks++; if (cap_bits[FB-1] !== 1'b1) begin n_errors++; $display("FAIL all16_last_bit got=%b exp=1", cap_bits[FB-1]); end
        n_checks++; if (nvalid != FB || ndone != 1 || done_at != FB) begin n_errors++; $display("FAIL all16_framing valid=%0d done=%0d at=%0d exp=%0d/1/%0d", nvalid, ndone, done_at, FB, FB); end
    endtask

    task automatic test_run3();
        bit ok;
        do_reset();
        start_feed(1);
        wait_full(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL run3_preload got=not_full exp=full"); end
        model_frame(1'b1);
        capture_frame(-1, -1);
        n_checks++; if (runs_sent !== 11'd342 || exp_runs != 342) begin n_errors++; $display("FAIL run3_runs_sent got=%0d exp=342", runs_sent); end
        n_checks++; if (cap_bits[FB-2] !== 1'b0 || cap_bits[FB-1] !== 1'b1) begin n_errors++; $display("FAIL run3_truncated_tail got=%b%b exp=01", cap_bits[FB-2], cap_bits[FB-1]); end
        n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL run3_bits diffs=%0d exp=0", count_diffs()); end
        model_frame(1'b1);
        capture_frame(-1, -1);
        n_checks++; if (cap_bits[2] !== 1'b0 || cap_bits[3] !== 1'b1) begin n_errors++; $display("FAIL run3_retained_head got=%b%b exp=01", cap_bits[2], cap_bits[3]); end
        n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL run3_next_frame_bits diffs=%0d exp=0", count_diffs()); end
        n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL run3_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        start_feed(2);
        wait_full(ok);
        model_frame(1'b1);
        capture_frame(300, FB);
        n_checks++; if (nvalid != FB || gaps != 0) begin n_errors++; $display("FAIL ignore_start_len got=%0d gaps=%0d exp=%0d", nvalid, gaps, FB); end
        n_checks++; if (ndone != 1 || done_at != FB) begin n_errors++; $display("FAIL ignore_start_done count=%0d at=%0d exp=1 at %0d", ndone, done_at, FB); end
        n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL ignore_start_bits diffs=%0d exp=0", count_diffs()); end
        n_checks++; if (runs_sent !== 11'(exp_runs)) begin n_errors++; $display("FAIL ignore_start_runs got=%0d exp=%0d", runs_sent, exp_runs); end
    endtask

    task automatic test_histogram();
        bit ok;
        start_feed(3);
        wait_full(ok);
        model_frame(1'b1);
        capture_frame(-1, -1);
        for (int b = 1; b <= 16; b++) begin
            n_checks++;
            if (cap_hist[b] != exp_hist[b]) begin n_errors++; $display("FAIL hist_bin%0d got=%0d exp=%0d", b, cap_hist[b], exp_hist[b]); end
        end
        n_checks++; if (cap_max_run > 16) begin n_errors++; $display("FAIL hist_max_run got=%0d exp<=16", cap_max_run); end
        n_checks++; if (runs_sent !== 11'(exp_runs)) begin n_errors++; $display("FAIL hist_runs_sent got=%0d exp=%0d", runs_sent, exp_runs); end
    endtask

    task automatic test_random();
        bit ok;
        start_feed(2);
        wait_full(ok);
        for (int f = 0; f < 2; f++) begin
            model_frame(1'b1);
            capture_frame(-1, -1);
            n_checks++; if (count_diffs() != 0) begin n_errors++; $display("FAIL random%0d_bits diffs=%0d exp=0", f, count_diffs()); end
            n_checks++; if (runs_sent !== 11'(exp_runs)) begin n_errors++; $display("FAIL random%0d_runs got=%0d exp=%0d", f, runs_sent, exp_runs); end
            n_checks++; if (underrun !== 1'b0) begin n_errors++; $display("FAIL random%0d_underrun got=%b exp=0", f, underrun); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int spurious;
        start_feed(2);
        wait_full(ok);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c <= 500; c++) @(negedge clk);
        n_checks++; if (data_valid !== 1'b1) begin n_errors++; $display("FAIL midreset_active got=%b exp=1", data_valid); end
        feed_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (data_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_data_valid got=%b exp=0", data_valid); end
        n_checks++; if (run_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_run_ready got=%b exp=1", run_ready); end
        n_checks++; if (runs_sent !== 11'd0) begin n_errors++; $display("FAIL midreset_runs_sent got=%0d exp=0", runs_sent); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL midreset_frame_done got=%b exp=0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || data_valid !== 1'b0) spurious++;
        end
        n_checks++; if (spurious != 0) begin n_errors++; $display("FAIL midreset_quiet got=%0d exp=0", spurious); end
        cons_idx = fed_idx;
    endtask

    initial begin
        test_reset();
        test_preload_underrun();
        test_all16();
        test_run3();
        test_start_ignored();
        test_histogram();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/run_length_tx.md
RUN_LENGTH_TX -- requirements
Module: run_length_tx

Interface
REQ-001 Parameter FRAME_BITS, default 1024, bits per frame.
REQ-002 Parameter MAX_RUN, default 16, longest run length.
REQ-003 Parameter FIFO_DEPTH, default 4, run-length FIFO entries.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a frame.
REQ-007 run_valid  input  1  run_len is valid.
REQ-008 run_len  input  4  requested run length, 1..15 literal, 0 encodes 16.
REQ-009 run_ready  output  1  FIFO can accept a run_len.
REQ-010 data_valid  output  1  high for exactly FRAME_BITS consecutive cycles per frame.
REQ-011 data_out  output  1  serial bitstream.
REQ-012 frame_done  output  1  one-cycle pulse after the last frame bit.
REQ-013 underrun  output  1  sticky flag: FIFO was empty when a new run was needed.
REQ-014 runs_sent  output  11  number of runs started in the current or last frame.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-016 run_ready SHALL equal FIFO not-full in every state, so runs can be preloaded in IDLE; push on run_valid & run_ready.
REQ-017 start SHALL be honoured only in IDLE; the FSM moves to SEND on the next edge; start in SEND or DONE SHALL be ignored.
REQ-018 On accepted start, underrun, runs_sent, the bit counter and the level (0) SHALL be cleared; the first data_valid=1 cycle is the cycle after start.
REQ-019 In SEND, data_valid SHALL be 1 and data_out SHALL equal the current level every cycle, one bit per cycle, no gaps.
REQ-020 At the first bit of each run, the head of the FIFO SHALL be popped and loaded as run length; the level SHALL toggle at each run boundary except before the first run.
REQ-021 If the FIFO is empty when a run starts, a run of length 1 SHALL be emitted and underrun set; a simultaneous push SHALL NOT bypass to the pop (underrun still set).
REQ-022 runs_sent SHALL increment at the first bit of every run, including underrun fills, saturating never (max 1024 fits).
REQ-023 After bit FRAME_BITS-1, the FSM SHALL go to DONE: data_valid=0, data_out=0, frame_done=1 for one cycle, then IDLE.
REQ-024 A run still in progress at frame end SHALL be truncated; its remainder SHALL be discarded; unpopped FIFO entries SHALL be retained for the next frame.
REQ-025 In IDLE and DONE, data_valid and data_out SHALL be 0.
REQ-026 No run emitted SHALL exceed MAX_RUN bits; consecutive runs SHALL differ in level.

Reset
REQ-027 With rst_n=0 at a clock edge: FSM=IDLE, FIFO empty, run_ready=1 the next cycle, data_valid=0, data_out=0, frame_done=0, underrun=0, runs_sent=0, level=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse.

Structure
REQ-029 Package run_length_pkg SHALL hold the FSM state enum, FRAME_BITS/MAX_RUN defaults and the run_len 0→16 decode function.
REQ-030 The FIFO SHALL be a separate sub-module run_len_fifo (synchronous, FIFO_DEPTH x 4, full/empty outputs).

Verification
REQ-031 Preload 5,3,0(16) then start -> data_out 00000 111 0000000000000000 then underrun fill 1,0,1...; underrun=1, data_valid high exactly 1024 cycles, frame_done one cycle after.
REQ-032 Continuous feed of run_len=0 (16) -> 64 runs of 16, runs_sent=64, underrun=0, bit 1023 = 1.
REQ-033 Continuous feed of run_len=3 -> last run truncated to 1 bit (1024 mod 3 = 1), runs_sent=342, next FIFO entry retained for next frame.
REQ-034 start pulsed during SEND and during DONE -> ignored; frame length still 1024, single frame_done.
REQ-035 rst_n=0 at bit 500 -> next cycle data_valid=0, run_ready=1, runs_sent=0, no frame_done.
REQ-036 Loopback into the existing histogram checker: feeding runs 1..16 cyclically -> histogram bins match the fed counts (truncated final run counted at its truncated length).
